// File: rtl/div.sv
// div: iterative 32-bit divider for the EX stage (DIV / DIVU).
//
// Ports
//   clk           pipeline clock, rising edge
//   rst           asynchronous reset, active low
//   signed_div_i  1 = signed (two's complement) divide, 0 = unsigned
//   opdata1_i     dividend, sampled on the accepting edge only
//   opdata2_i     divisor, sampled on the accepting edge only
//   start_i       divide request, held by EX until ready_o is seen
//   annul_i       flush of the in-flight divide
//   result_o      {remainder, quotient}; upper half to HI, lower half to LO
//   ready_o       result_o valid for the current request
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FREE   | idle, outputs zero, waiting for start_i without annul_i
// S_BYZERO | divisor was zero; next edge reports a zero result
// S_ON     | one restoring shift-subtract step per edge, 32 steps
// S_END    | result held until EX drops start_i

module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [64:0] work_q;
    logic [31:0] divisor_q;
    logic        signed_q;
    logic        sign1_q;
    logic        sign2_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] partial;
    logic        ge;
    logic [31:0] diff;
    logic [64:0] work_d;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Magnitudes of the incoming operands; DIVU uses them unchanged.
    always_comb begin
        mag1 = opdata1_i;
        mag2 = opdata2_i;
        if (signed_div_i && opdata1_i[31]) begin
            mag1 = ~opdata1_i + 32'd1;
        end
        if (signed_div_i && opdata2_i[31]) begin
            mag2 = ~opdata2_i + 32'd1;
        end
    end

    // Working register layout: [64:33] partial remainder, [32:1] dividend
    // bits still to consume followed by quotient bits, [0] newest quotient bit.
    // The compare uses all 33 bits of the shifted remainder so that divisors
    // with bit 31 set are handled correctly for DIVU.
    always_comb begin
        partial = work_q[64:32];
        ge      = (partial >= {1'b0, divisor_q});
        // Whenever ge holds the difference is below the divisor, so 32 bits suffice.
        diff    = partial[31:0] - divisor_q;
        work_d  = {work_q[63:0], 1'b0};
        if (ge) begin
            work_d = {diff, work_q[31:0], 1'b1};
        end
    end

    always_comb begin
        quot     = work_q[31:0];
        rem      = work_q[64:33];
        quot_fix = quot;
        rem_fix  = rem;
        if (signed_q && (sign1_q ^ sign2_q)) begin
            quot_fix = ~quot + 32'd1;
        end
        if (signed_q && sign1_q) begin
            rem_fix = ~rem + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FREE;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= 64'd0;
                    if (start_i && !annul_i) begin
                        signed_q  <= signed_div_i;
                        sign1_q   <= signed_div_i & opdata1_i[31];
                        sign2_q   <= signed_div_i & opdata2_i[31];
                        divisor_q <= mag2;
                        work_q    <= {32'd0, mag1, 1'b0};
                        cnt_q     <= 6'd0;
                        state_q   <= (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
                    end
                end
                S_BYZERO: begin
                    if (annul_i) begin
                        state_q  <= S_FREE;
                        cnt_q    <= 6'd0;
                        ready_q  <= 1'b0;
                        result_q <= 64'd0;
                    end else begin
                        state_q  <= S_END;
                        ready_q  <= 1'b1;
                        result_q <= 64'd0;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state_q  <= S_FREE;
                        cnt_q    <= 6'd0;
                        ready_q  <= 1'b0;
                        result_q <= 64'd0;
                    end else if (cnt_q == 6'd32) begin
                        state_q  <= S_END;
                        ready_q  <= 1'b1;
                        result_q <= {rem_fix, quot_fix};
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 6'd1;
                    end
                end
                S_END: begin
                    // annul_i is ignored here; only the drop of start_i releases the result.
                    if (!start_i) begin
                        state_q  <= S_FREE;
                        ready_q  <= 1'b0;
                        result_q <= 64'd0;
                    end
                end
                default: begin
                    state_q <= S_FREE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int tests_run;
    int tests_failed;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge; inputs are driven and
    // outputs sampled at that point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait 33 edges past the accepting edge, capture the
    // outputs, then drop start_i and let the block return to FREE.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [63:0] res, output logic rdy);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();
        repeat (33) tick();
        res     = result_o;
        rdy     = ready_o;
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start_i = 1'b1;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        #12;
        tests_run++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%b result=%h, want 0/0", ready_o, result_o);
        end
        tick();
        tick();
        tests_run++;
        if (ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: ready=%b with rst low, want 0", ready_o);
        end
        rst = 1'b1;
        start_i = 1'b0;
        tick();
        tick();
        tests_run++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL idle_free: ready=%b result=%h, want 0/0", ready_o, result_o);
        end
        // start with annul in FREE must not be accepted
        start_i = 1'b1;
        annul_i = 1'b1;
        tick();
        tick();
        tests_run++;
        if (ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL annul_blocks_accept: ready=%b, want 0", ready_o);
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int early_bad;
        early_bad = 0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        tick();
        if (ready_o !== 1'b0) early_bad++;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (ready_o !== 1'b0) early_bad++;
        end
        tests_run++;
        if (early_bad != 0) begin
            tests_failed++;
            $display("FAIL unsigned_early_ready: %0d early edges with ready=1, want 0", early_bad);
        end
        tick();
        tests_run++;
        if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
            tests_failed++;
            $display("FAIL unsigned_100_7: ready=%b result=%h, want 1/000000020000000e", ready_o, result_o);
        end
        start_i = 1'b0;
        tick();
        tests_run++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL unsigned_release: ready=%b result=%h, want 0/0", ready_o, result_o);
        end
    endtask

    // Back-to-back requests from a table; each starts right after the previous returns to FREE.
    task automatic test_vectors();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        vs [8];
        logic [63:0] ve [8];
        logic [63:0] res;
        logic        rdy;
        va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;        vs[0] = 1'b1; ve[0] = 64'hFFFFFFFF_FFFFFFFD;
        va[1] = 32'h80000000; vb[1] = 32'hFFFFFFFF; vs[1] = 1'b1; ve[1] = 64'h00000000_80000000;
        va[2] = 32'hFFFFFFFF; vb[2] = 32'd1;        vs[2] = 1'b0; ve[2] = 64'h00000000_FFFFFFFF;
        va[3] = 32'hFFFFFF9C; vb[3] = 32'hFFFFFFF9; vs[3] = 1'b1; ve[3] = 64'hFFFFFFFE_0000000E;
        va[4] = 32'd7;        vb[4] = 32'hFFFFFFFE; vs[4] = 1'b1; ve[4] = 64'h00000001_FFFFFFFD;
        va[5] = 32'hFFFFFFF9; vb[5] = 32'd2;        vs[5] = 1'b0; ve[5] = 64'h00000001_7FFFFFFC;
        va[6] = 32'hFFFFFFFF; vb[6] = 32'hFFFFFFFE; vs[6] = 1'b0; ve[6] = 64'h00000001_00000001;
        va[7] = 32'd3;        vb[7] = 32'd10;       vs[7] = 1'b0; ve[7] = 64'h00000003_00000000;
        for (int i = 0; i < 8; i++) begin
            run_div(va[i], vb[i], vs[i], res, rdy);
            tests_run++;
            if (rdy !== 1'b1 || res !== ve[i]) begin
                tests_failed++;
                $display("FAIL vector_%0d (%h/%h s=%b): ready=%b result=%h, want 1/%h",
                         i, va[i], vb[i], vs[i], rdy, res, ve[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] res;
        logic        rdy;
        signed_div_i = 1'b0;
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        start_i = 1'b1;
        tick();
        tests_run++;
        if (ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL byzero_accept_edge: ready=%b, want 0", ready_o);
        end
        tick();
        tests_run++;
        if (ready_o !== 1'b1 || result_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL byzero_result: ready=%b result=%h, want 1/0", ready_o, result_o);
        end
        start_i = 1'b0;
        tick();
        tests_run++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL byzero_release: ready=%b result=%h, want 0/0", ready_o, result_o);
        end
        // annul while in BYZERO
        start_i = 1'b1;
        tick();
        annul_i = 1'b1;
        tick();
        tests_run++;
        if (ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL byzero_annul: ready=%b, want 0", ready_o);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();
        run_div(32'd9, 32'd3, 1'b0, res, rdy);
        tests_run++;
        if (rdy !== 1'b1 || res !== 64'h00000000_00000003) begin
            tests_failed++;
            $display("FAIL byzero_annul_recover: ready=%b result=%h, want 1/3", rdy, res);
        end
    endtask

    task automatic test_annul();
        int early_bad;
        early_bad = 0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        tick();
        repeat (9) tick();
        annul_i = 1'b1;
        tick();
        tests_run++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL annul_on: ready=%b result=%h, want 0/0", ready_o, result_o);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        tick();
        if (ready_o !== 1'b0) early_bad++;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (ready_o !== 1'b0) early_bad++;
        end
        tests_run++;
        if (early_bad != 0) begin
            tests_failed++;
            $display("FAIL annul_restart_early: %0d early edges with ready=1, want 0", early_bad);
        end
        tick();
        tests_run++;
        if (ready_o !== 1'b1 || result_o !== 64'h00000000_00000003) begin
            tests_failed++;
            $display("FAIL annul_restart_9_3: ready=%b result=%h, want 1/3", ready_o, result_o);
        end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int early_bad;
        early_bad = 0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        tick();
        repeat (15) tick();
        #3;
        rst = 1'b0;
        #1;
        tests_run++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_on: ready=%b result=%h, want 0/0", ready_o, result_o);
        end
        #2;
        rst = 1'b1;
        opdata1_i = 32'd20;
        opdata2_i = 32'd6;
        tick();
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (ready_o !== 1'b0) early_bad++;
        end
        tests_run++;
        if (early_bad != 0) begin
            tests_failed++;
            $display("FAIL reset_restart_early: %0d early edges with ready=1, want 0", early_bad);
        end
        tick();
        tests_run++;
        if (ready_o !== 1'b1 || result_o !== 64'h00000002_00000003) begin
            tests_failed++;
            $display("FAIL reset_restart_20_6: ready=%b result=%h, want 1/0000000200000003", ready_o, result_o);
        end
        // asynchronous reset while a result is being held
        #3;
        rst = 1'b0;
        #1;
        tests_run++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_async_end: ready=%b result=%h, want 0/0", ready_o, result_o);
        end
        start_i = 1'b0;
        #1;
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_hold();
        logic [63:0] exp;
        int          hold_bad;
        exp = 64'h00000006_0000008E;
        hold_bad = 0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        tick();
        // operand changes after acceptance must be ignored
        opdata1_i = 32'hFFFFFFF0;
        opdata2_i = 32'd0;
        signed_div_i = 1'b1;
        repeat (32) tick();
        opdata2_i = 32'd5;
        tick();
        tests_run++;
        if (ready_o !== 1'b1 || result_o !== exp) begin
            tests_failed++;
            $display("FAIL hold_result: ready=%b result=%h, want 1/%h", ready_o, result_o, exp);
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 2) annul_i = 1'b1;
            tick();
            if (ready_o !== 1'b1 || result_o !== exp) hold_bad++;
        end
        tests_run++;
        if (hold_bad != 0) begin
            tests_failed++;
            $display("FAIL hold_stable: %0d edges changed, last ready=%b result=%h, want 1/%h",
                     hold_bad, ready_o, result_o, exp);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();
        tests_run++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            tests_failed++;
            $display("FAIL hold_release: ready=%b result=%h, want 0/0", ready_o, result_o);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b0;
        start_i = 1'b0;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        test_reset();
        test_unsigned();
        test_vectors();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; asynchronous, active-low; while rst=0 the block is held in reset state.
REQ-003 signed_div_i  input  1  1 = DIV (two's-complement operands); 0 = DIVU (unsigned).
REQ-004 opdata1_i  input  32  dividend; sampled only on the accepting edge.
REQ-005 opdata2_i  input  32  divisor; sampled only on the accepting edge.
REQ-006 start_i  input  1  EX-stage divide request; held high by EX until ready_o seen, then dropped.
REQ-007 annul_i  input  1  cancel in-flight divide; asserted when the instruction is flushed.
REQ-008 result_o  output  64  {remainder[31:0], quotient[31:0]}; upper half goes to HI, lower half to LO.
REQ-009 ready_o  output  1  1 = result_o valid for the current request.

Function
REQ-010 The block SHALL implement a 4-state FSM: FREE, BYZERO, ON, END.
REQ-011 FREE: if start_i=1 and annul_i=0 at an edge, the block SHALL accept; next state BYZERO if opdata2_i=0, else ON. Otherwise it remains in FREE with ready_o=0 and result_o=0.
REQ-012 On accept with signed_div_i=1, each negative operand SHALL be replaced by its two's-complement magnitude before iteration; with signed_div_i=0, operands SHALL be used as-is.
REQ-013 On accept, the block SHALL latch signs, signed_div_i and operand magnitudes, and clear a 6-bit iteration counter; later input changes SHALL be ignored until return to FREE.
REQ-014 ON: each edge SHALL perform one restoring shift-subtract step on a 65-bit working register, producing one quotient bit, MSB first, and increment the counter.
REQ-015 Shift-subtract step: if partial remainder >= divisor, subtract and shift in 1; else shift in 0 without subtracting.
REQ-016 When the counter reaches 32 in ON, the next edge SHALL: apply sign correction, load result_o, set ready_o=1, and enter END.
REQ-017 Sign correction (signed only): quotient SHALL be negated if the operand signs differ; remainder SHALL take the dividend's sign.
REQ-018 Latency: a divide accepted at edge N SHALL show ready_o=1 with valid result_o after edge N+33.
REQ-019 BYZERO: the next edge SHALL enter END with result_o=0 and ready_o=1 (accepted at N gives ready after N+1).
REQ-020 END: result_o and ready_o SHALL hold while start_i=1; on the first edge with start_i=0, the block SHALL enter FREE with ready_o=0 and result_o=0.
REQ-021 annul_i=1 in ON or BYZERO SHALL force FREE on that edge, with ready_o=0, result_o=0, and counter cleared; no result is produced.
REQ-022 annul_i in END SHALL have no effect; start_i governs exit.
REQ-023 0x80000000 / 0xFFFFFFFF (signed) SHALL return quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-024 The divider SHALL be fully occupied; a new request SHALL be accepted only from FREE.

Reset
REQ-025 rst=0 SHALL asynchronously force: state FREE, ready_o=0, result_o=0, counter=0, working register=0.
REQ-026 Reset asserted mid-ON SHALL abandon the divide; after release, the block SHALL be in FREE and accept a new start_i on the first following edge.

Verification
REQ-027 Unsigned: 100 / 7 accepted at edge N -> ready_o=1 after edge N+33; result_o=0x00000002_0000000E; ready_o=0 at every earlier edge.
REQ-028 Signed: -7 (0xFFFFFFF9) / 2 -> result_o=0xFFFFFFFF_FFFFFFFD; signed 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000; unsigned 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF.
REQ-029 Divide by zero: 5 / 0 -> ready_o=1 after edge N+1, result_o=0; start_i dropped -> next edge ready_o=0, state FREE.
REQ-030 Annul: 1000 / 3 started at N, annul_i=1 at edge N+10 -> ready_o=0 and result_o=0 from N+10; a new 9 / 3 at N+12 -> result_o=0x00000000_00000003 after N+45.
REQ-031 Reset mid-operation: rst low at N+15 (asynchronous, between edges) -> outputs 0 immediately; after release, 20 / 6 completes normally with result_o=0x00000002_00000003.
REQ-032 Hold: with start_i kept high for 5 edges after ready_o, result_o SHALL stay constant; operand changes during ON SHALL not alter the result.
